// File: rtl/zebra_frame_generator.sv
// Synthetic grayscale frame source: horizontal white bands on a black
// background, streamed over a valid/ready interface, with a per-frame
// count of the white pixels that were actually transferred.
//
// Handshake: a beat transfers on a rising clk edge where y_valid && y_ready.
// Once y_valid rises, y_data/sof/eol/eof stay frozen until that beat
// transfers, and y_valid only drops after a transfer (or on rst).
module zebra_frame_generator #(
    parameter int             IMG_WIDTH   = 640,
    parameter int             IMG_HEIGHT  = 480,
    parameter int             W           = 8,
    parameter logic [W-1:0]   WHITE_LEVEL = 8'd255,
    parameter logic [W-1:0]   BLACK_LEVEL = 8'd16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    continuous,
    input  logic [$clog2(IMG_HEIGHT)-1:0]           band_start_row,
    input  logic [$clog2(IMG_HEIGHT)-1:0]           stripe_rows,
    input  logic [7:0]                              num_stripes,
    output logic                                    y_valid,
    input  logic                                    y_ready,
    output logic [W-1:0]                            y_data,
    output logic                                    sof,
    output logic                                    eol,
    output logic                                    eof,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] white_count
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int CW = $clog2(IMG_WIDTH*IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] Y_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic          ONE_COL = (IMG_WIDTH == 1);
    localparam logic          ONE_PIX = (IMG_WIDTH == 1) && (IMG_HEIGHT == 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t         state_q;
    logic [XW-1:0]  x_q;
    logic [RW-1:0]  y_q;

    // Latched frame configuration
    logic [RW-1:0]  bsr_q;
    logic [RW-1:0]  sr_q;
    logic [7:0]     ns_q;

    // Band tracking for the row currently being presented
    logic           in_band_q;   // row index has reached band_start_row
    logic [RW-1:0]  row_cnt_q;   // row offset within the current stripe/gap
    logic           phase_q;     // 0: white stripe, 1: black gap
    logic [7:0]     stripes_q;   // white stripes fully emitted so far
    logic           cur_white_q; // presented beat is a white pixel

    logic [CW-1:0]  acc_q;

    logic           y_valid_q, sof_q, eol_q, eof_q, busy_q, frame_done_q;
    logic [W-1:0]   y_data_q;
    logic [CW-1:0]  white_count_q;

    logic           fire, load, ld_white;
    logic [CW-1:0]  acc_plus;
    logic [XW-1:0]  x_d;
    logic [RW-1:0]  y_d;
    logic           eol_d, eof_d;
    logic           in_band_d, phase_d, white_d;
    logic [RW-1:0]  row_cnt_d;
    logic [7:0]     stripes_d;

    // Next-beat position and next-row band state; no division needed because
    // the stripe/gap structure is walked one row at a time.
    always_comb begin
        fire     = y_valid_q && y_ready;
        load     = ((state_q == S_IDLE) && start) ||
                   ((state_q == S_STREAM) && fire && eof_q && continuous);
        acc_plus = acc_q + CW'(cur_white_q);
        ld_white = (band_start_row == '0) && (stripe_rows != '0) && (num_stripes != 8'd0);

        x_d   = eol_q ? '0 : x_q + XW'(1);
        y_d   = eol_q ? y_q + RW'(1) : y_q;
        eol_d = (x_d == X_LAST);
        eof_d = eol_d && (y_d == Y_LAST);

        in_band_d = in_band_q;
        row_cnt_d = row_cnt_q;
        phase_d   = phase_q;
        stripes_d = stripes_q;
        if (!in_band_q) begin
            if (y_d == bsr_q) begin
                in_band_d = 1'b1;
                row_cnt_d = '0;
                phase_d   = 1'b0;
                stripes_d = 8'd0;
            end
        end else if (row_cnt_q == sr_q - RW'(1)) begin
            row_cnt_d = '0;
            phase_d   = ~phase_q;
            if (!phase_q && (stripes_q != 8'hFF)) begin
                stripes_d = stripes_q + 8'd1;
            end
        end else begin
            row_cnt_d = row_cnt_q + RW'(1);
        end
        white_d = in_band_d && !phase_d && (stripes_d < ns_q) && (sr_q != '0);
    end

    // Frame FSM, beat counters, band walker and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            bsr_q         <= '0;
            sr_q          <= '0;
            ns_q          <= 8'd0;
            in_band_q     <= 1'b0;
            row_cnt_q     <= '0;
            phase_q       <= 1'b0;
            stripes_q     <= 8'd0;
            cur_white_q   <= 1'b0;
            acc_q         <= '0;
            y_valid_q     <= 1'b0;
            y_data_q      <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            white_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;

            if (fire && eof_q) begin
                white_count_q <= acc_plus;
                frame_done_q  <= 1'b1;
            end

            if (load) begin
                state_q     <= S_STREAM;
                bsr_q       <= band_start_row;
                sr_q        <= stripe_rows;
                ns_q        <= num_stripes;
                x_q         <= '0;
                y_q         <= '0;
                in_band_q   <= (band_start_row == '0);
                row_cnt_q   <= '0;
                phase_q     <= 1'b0;
                stripes_q   <= 8'd0;
                cur_white_q <= ld_white;
                y_data_q    <= ld_white ? WHITE_LEVEL : BLACK_LEVEL;
                acc_q       <= '0;
                y_valid_q   <= 1'b1;
                busy_q      <= 1'b1;
                sof_q       <= 1'b1;
                eol_q       <= ONE_COL;
                eof_q       <= ONE_PIX;
            end else if (fire) begin
                if (eof_q) begin
                    state_q   <= S_IDLE;
                    y_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    sof_q     <= 1'b0;
                    eol_q     <= 1'b0;
                    eof_q     <= 1'b0;
                end else begin
                    acc_q <= acc_plus;
                    sof_q <= 1'b0;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    eol_q <= eol_d;
                    eof_q <= eof_d;
                    if (eol_q) begin
                        in_band_q   <= in_band_d;
                        row_cnt_q   <= row_cnt_d;
                        phase_q     <= phase_d;
                        stripes_q   <= stripes_d;
                        cur_white_q <= white_d;
                        y_data_q    <= white_d ? WHITE_LEVEL : BLACK_LEVEL;
                    end
                end
            end
        end
    end

    assign y_valid     = y_valid_q;
    assign y_data      = y_data_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign white_count = white_count_q;

endmodule

// File: tb/tb_zebra_frame_generator.sv
// Directed bench for zebra_frame_generator on an 8x6 frame.
module tb_zebra_frame_generator;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int NB = IW * IH;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic [2:0] band_start_row;
  logic [2:0] stripe_rows;
  logic [7:0] num_stripes;
  logic       y_valid;
  logic       y_ready;
  logic [7:0] y_data;
  logic       sof, eol, eof, busy, frame_done;
  logic [5:0] white_count;

  int n_checks = 0;
  int n_fail   = 0;

  zebra_frame_generator #(
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .continuous     (continuous),
    .band_start_row (band_start_row),
    .stripe_rows    (stripe_rows),
    .num_stripes    (num_stripes),
    .y_valid        (y_valid),
    .y_ready        (y_ready),
    .y_data         (y_data),
    .sof            (sof),
    .eol            (eol),
    .eof            (eof),
    .busy           (busy),
    .frame_done     (frame_done),
    .white_count    (white_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference row rule written directly from the band definition
  function automatic bit exp_white(int r, int bsr, int sr, int ns);
    int q;
    if (sr == 0 || ns == 0 || r < bsr) return 1'b0;
    q = (r - bsr) / sr;
    return ((q % 2) == 0) && (q < 2 * ns);
  endfunction

  // issue a start from IDLE; called and returns on a negedge
  task automatic start_frame(input int bsr, input int sr, input int ns);
    band_start_row = 3'(bsr);
    stripe_rows    = 3'(sr);
    num_stripes    = 8'(ns);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_valid", y_valid, 1);
    chk("start_busy", busy, 1);
  endtask

  // consume one frame whose first beat is valid at the current negedge
  task automatic run_frame(input string tag, input int bsr, input int sr, input int ns,
                           input bit rnd, input bit cont_next, input bit poke_start,
                           input int exp_wc);
    int beat, cycles, r, c;
    bit w;
    beat = 0;
    cycles = 0;
    while (beat < NB) begin
      if (cycles > 1000) begin
        chk({tag, "_timeout_beats"}, beat, NB);
        break;
      end
      r = beat / IW;
      c = beat % IW;
      w = exp_white(r, bsr, sr, ns);
      chk({tag, "_valid"}, y_valid, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_data"}, y_data, w ? 8'd255 : 8'd16);
      chk({tag, "_sof"}, sof, (beat == 0));
      chk({tag, "_eol"}, eol, (c == IW - 1));
      chk({tag, "_eof"}, eof, (beat == NB - 1));
      if (poke_start) start = (beat == 10);
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (y_ready) beat++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    y_ready = 1'b1;
    chk({tag, "_frame_done"}, frame_done, 1);
    chk({tag, "_white_count"}, white_count, exp_wc);
    if (cont_next) begin
      chk({tag, "_next_sof_valid"}, y_valid, 1);
      chk({tag, "_next_sof"}, sof, 1);
    end else begin
      chk({tag, "_idle_valid"}, y_valid, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      @(negedge clk);
      chk({tag, "_frame_done_drop"}, frame_done, 0);
      chk({tag, "_stay_idle"}, y_valid, 0);
      chk({tag, "_wc_hold"}, white_count, exp_wc);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    band_start_row = '0;
    stripe_rows = '0;
    num_stripes = '0;
    y_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_valid", y_valid, 0);
    chk("rst_data", y_data, 0);
    chk("rst_sof", sof, 0);
    chk("rst_eol", eol, 0);
    chk("rst_eof", eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_white_count", white_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: rows 1 and 3 white, full-rate sink
    start_frame(1, 1, 2);
    run_frame("t1", 1, 1, 2, 1'b0, 1'b0, 1'b0, 16);

    // 2: same frame with random back-pressure; inputs scrambled mid-frame
    start_frame(1, 1, 2);
    band_start_row = 3'd0;
    stripe_rows    = 3'd3;
    num_stripes    = 8'd5;
    run_frame("t2", 1, 1, 2, 1'b1, 1'b0, 1'b0, 16);

    // 3: degenerate configs give an all-black frame
    start_frame(1, 1, 0);
    run_frame("t3a", 1, 1, 0, 1'b1, 1'b0, 1'b0, 0);
    start_frame(1, 0, 2);
    run_frame("t3b", 1, 0, 2, 1'b0, 1'b0, 1'b0, 0);

    // 4: bands clipped at the bottom of the frame
    start_frame(4, 2, 3);
    run_frame("t4", 4, 2, 3, 1'b0, 1'b0, 1'b0, 16);

    // 5: back-to-back frames; frame 2 picks up the config present at frame 1 eof
    continuous = 1'b1;
    start_frame(1, 1, 2);
    band_start_row = 3'd4;
    stripe_rows    = 3'd2;
    num_stripes    = 8'd3;
    run_frame("t5f1", 1, 1, 2, 1'b0, 1'b1, 1'b0, 16);
    continuous = 1'b0;
    run_frame("t5f2", 4, 2, 3, 1'b0, 1'b0, 1'b0, 16);

    // 6: reset mid-frame, then a clean frame with a stray start inside it
    start_frame(0, 1, 1);
    y_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_valid", y_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_white_count", white_count, 0);
    chk("t6_rst_frame_done", frame_done, 0);
    @(negedge clk);
    chk("t6_idle_after_rst", y_valid, 0);
    start_frame(1, 1, 2);
    run_frame("t6", 1, 1, 2, 1'b0, 1'b0, 1'b1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zebra_frame_generator.md
Name: zebra_frame_generator

Overview:
Synthetic pixel-stream source that drives the valid/ready grayscale stream consumed by the zebra crossing detection path. It emits full frames of IMG_WIDTH x IMG_HEIGHT pixels containing a programmable set of horizontal white bands on a black background. It also reports the number of white pixels it emitted in each frame, which the bench scoreboards against the detector's per-frame white count.

Parameters:
IMG_WIDTH, 640, pixels per row
IMG_HEIGHT, 480, rows per frame
W, 8, pixel data width
WHITE_LEVEL, 8'd255, value emitted for band pixels
BLACK_LEVEL, 8'd16, value emitted for background pixels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request one frame; sampled only in IDLE
continuous  in  1  when high at the last beat of a frame, begin the next frame with no gap
band_start_row  in  $clog2(IMG_HEIGHT)  first row of the first white band
stripe_rows  in  $clog2(IMG_HEIGHT)  height in rows of each white band and each black gap
num_stripes  in  8  number of white bands
y_valid  out  1  output beat valid
y_ready  in  1  downstream ready
y_data  out  W  pixel value
sof  out  1  beat is pixel (0,0)
eol  out  1  beat is the last pixel of a row
eof  out  1  beat is the last pixel of the frame
busy  out  1  high in STREAM
frame_done  out  1  one-cycle pulse after the eof handshake
white_count  out  $clog2(IMG_WIDTH*IMG_HEIGHT)  white pixels emitted in the last completed frame

Behaviour:
- All outputs are registered. Reset values: y_valid=0, y_data=0, sof/eol/eof=0, busy=0, frame_done=0, white_count=0. The FSM resets to IDLE and all counters reset to 0.
- Handshake: a beat transfers when y_valid && y_ready.
  - Once y_valid is high, y_data, sof, eol and eof hold stable until the beat transfers.
  - y_valid never drops without a transfer, except on rst.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM when start=1. In the same cycle, latch band_start_row, stripe_rows and num_stripes. The first beat (pixel 0,0 with sof=1) is valid on the next cycle, so latency is 1 cycle.
  - STREAM: advance x/y on each transfer. x wraps at IMG_WIDTH-1 and increments y.
  - On the eof transfer with continuous=1: re-latch config and present pixel (0,0) of the next frame on the following cycle. There is no bubble when y_ready stays high.
  - On the eof transfer with continuous=0: go to IDLE, and y_valid=0 on the following cycle.
  - start is ignored while in STREAM.
- Band rule:
  - Row r is white iff r >= band_start_row and (r - band_start_row) / stripe_rows is even and < 2*num_stripes.
  - Implement this with a row-in-band counter, a phase bit and a stripes-emitted counter. No divider.
  - stripe_rows=0 or num_stripes=0 produces an all-BLACK_LEVEL frame.
  - Bands running past IMG_HEIGHT-1 are clipped silently; counters stop at frame end.
  - Every pixel in a white row is WHITE_LEVEL.
- white_count:
  - An internal accumulator adds 1 per transferred WHITE_LEVEL beat and clears at each frame start.
  - On the eof transfer, white_count <= accumulator plus the eof beat's contribution.
  - white_count holds that value until the next frame's eof.
  - frame_done pulses in the cycle after the eof transfer, coincident with the white_count update being visible.
- Config inputs changing mid-frame have no effect; only the latched copies are used.
- rst mid-frame: on the next cycle the block is in IDLE with y_valid=0 and white_count=0. A subsequent start produces a clean frame beginning at sof.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=6, start with band_start_row=1, stripe_rows=1, num_stripes=2, y_ready=1 -> 48 beats. Rows 1 and 3 are 255, all other rows are 16. sof on beat 0; eol on beats 7, 15, ..., 47; eof on beat 47. frame_done one cycle after beat 47. white_count=16.
2. Same config with y_ready toggled pseudo-randomly at 50% -> identical beat sequence. y_data and sideband are stable through every stall. white_count=16.
3. num_stripes=0, then separately stripe_rows=0 -> all 48 beats are 16 and white_count=0 in both cases.
4. band_start_row=4, stripe_rows=2, num_stripes=3 -> only rows 4 and 5 are white (clipped). white_count=16, and eof still lands on beat 47.
5. continuous=1 with y_ready=1 -> the sof beat of frame 2 is valid in the cycle immediately after the eof transfer of frame 1. Deassert continuous during frame 2 -> IDLE after frame 2, with frame_done pulsing after each eof.
6. Assert rst at beat 20 -> next cycle y_valid=0, busy=0, white_count=0. A subsequent start produces a full frame starting with sof. start asserted during STREAM leaves the beat count at 48.
